// File: rtl/sort_step_scheduler.sv
// sort_step_scheduler: paces compare/swap steps of a sort engine with load/step handshakes.
// Define SORT_STEP_SINGLE_EN to allow single-stepping with step_pulse while PAUSED.
module sort_step_scheduler #(
  parameter int DELAY_SLOW = 100_000_000,
  parameter int DELAY_FAST = 10_000_000,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             run,
  input  logic             pause,
  input  logic             step_pulse,
  input  logic             fast,
  output logic             load_req,
  input  logic             load_ack,
  output logic             step_req,
  input  logic             step_ack,
  input  logic             engine_done,
  output logic             busy,
  output logic             sorted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] step_count
);
  localparam int DMAX = DELAY_SLOW > DELAY_FAST ? DELAY_SLOW : DELAY_FAST;
  localparam int DW = $clog2(DMAX + 1);
  typedef enum logic [2:0] {IDLE, LOAD, READY, WAIT, STEP, PAUSED, DONE} state_t;
  state_t cur, nxt;
  logic [DW-1:0] cnt, cnt_n;
  logic [31:0] lim;
  logic rst_ok, at_lim, clr_sc, inc_sc, single;
`ifdef SORT_STEP_SINGLE_EN
  assign single = step_pulse;
`else
  logic unused_pulse;
  assign unused_pulse = step_pulse;
  assign single = 1'b0;
`endif
  assign state  = cur;
  assign busy   = cur == WAIT || cur == STEP || cur == PAUSED;
  assign sorted = cur == DONE;
  // the limit follows fast immediately, so an overshot count still fires next cycle
  assign lim    = fast ? 32'(DELAY_FAST) : 32'(DELAY_SLOW);
  assign at_lim = 32'(cnt) + 32'd1 >= lim;
  always_comb begin
    nxt = cur;
    cnt_n = cnt;
    clr_sc = 1'b0;
    inc_sc = 1'b0;
    if (!enable) begin
      nxt = IDLE;
      cnt_n = '0;
    end else
      case (cur)
        IDLE:   if (!run) nxt = LOAD;
        LOAD:   if (load_ack) begin nxt = READY; clr_sc = 1'b1; end
        READY:  if (run) begin nxt = WAIT; cnt_n = '0; end
        WAIT:
          if (!run) begin nxt = READY; cnt_n = '0; end
          else if (pause) nxt = PAUSED;
          else if (at_lim) begin nxt = STEP; cnt_n = '0; end
          else cnt_n = cnt + DW'(1);
        PAUSED:
          if (!run) begin nxt = READY; cnt_n = '0; end
          else if (!pause) nxt = WAIT;
          else if (single) begin nxt = STEP; cnt_n = '0; end
        STEP:
          if (step_ack) begin
            inc_sc = 1'b1;
            nxt = engine_done ? DONE : (pause ? PAUSED : WAIT);
          end
        DONE:   if (!run) nxt = LOAD;
        default: nxt = IDLE;
      endcase
  end
  // rst_ok delays the first transition to the second edge after reset release
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rst_ok     <= 1'b0;
      cur        <= IDLE;
      cnt        <= '0;
      step_count <= '0;
      load_req   <= 1'b0;
      step_req   <= 1'b0;
    end else begin
      rst_ok <= 1'b1;
      if (rst_ok) begin
        cur      <= nxt;
        cnt      <= cnt_n;
        load_req <= nxt == LOAD;
        step_req <= nxt == STEP;
        if (clr_sc) step_count <= '0;
        else if (inc_sc && !(&step_count)) step_count <= step_count + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_sort_step_scheduler.sv
// tb_sort_step_scheduler: directed scenarios plus randomized traffic checked every cycle
// against a behavioural model of the scheduler's state rules.
module tb_sort_step_scheduler;
  localparam int DS = 8, DF = 2, CW = 4, SC_MAX = (1 << CW) - 1;
  localparam int IDLE = 0, LOAD = 1, READY = 2, WAIT = 3, STEP = 4, PAUSED = 5, DONE = 6;
  logic clk = 0, reset_n = 1;
  logic enable = 0, run = 0, pause = 0, step_pulse = 0, fast = 0;
  logic load_ack = 0, step_ack = 0, engine_done = 0;
  logic load_req, step_req, busy, sorted;
  logic [2:0] state;
  logic [CW-1:0] step_count;
  int n_cmp = 0, n_bad = 0;
  int ms = IDLE, mc = 0, msc = 0;
  bit m_rdy = 0, auto_ack = 0, sr_q = 0;
  int cyc_n = 0, last_rise = 0, rise_gap = 0, n_rise = 0;

  sort_step_scheduler #(.DELAY_SLOW(DS), .DELAY_FAST(DF), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .run(run), .pause(pause),
    .step_pulse(step_pulse), .fast(fast), .load_req(load_req), .load_ack(load_ack),
    .step_req(step_req), .step_ack(step_ack), .engine_done(engine_done), .busy(busy),
    .sorted(sorted), .state(state), .step_count(step_count));

  always #5 clk = ~clk;

  task automatic model_reset();
    ms = IDLE; mc = 0; msc = 0; m_rdy = 0;
  endtask

  task automatic model_step();
    int lim;
    bit single;
    if (!reset_n) begin model_reset(); return; end
    if (!m_rdy) begin m_rdy = 1; return; end
    lim = fast ? DF : DS;
`ifdef SORT_STEP_SINGLE_EN
    single = step_pulse;
`else
    single = 0;
`endif
    if (!enable) begin ms = IDLE; mc = 0; return; end
    if (ms == IDLE) begin if (!run) ms = LOAD; end
    else if (ms == LOAD) begin if (load_ack) begin ms = READY; msc = 0; end end
    else if (ms == READY) begin if (run) begin ms = WAIT; mc = 0; end end
    else if (ms == WAIT || ms == PAUSED) begin
      if (!run) begin ms = READY; mc = 0; end
      else if (ms == WAIT && pause) ms = PAUSED;
      else if (ms == PAUSED && !pause) ms = WAIT;
      else if (ms == PAUSED && single) begin ms = STEP; mc = 0; end
      else if (ms == WAIT && mc + 1 >= lim) begin ms = STEP; mc = 0; end
      else if (ms == WAIT) mc++;
    end
    else if (ms == STEP) begin
      if (step_ack) begin
        msc = msc < SC_MAX ? msc + 1 : SC_MAX;
        ms = engine_done ? DONE : (pause ? PAUSED : WAIT);
      end
    end
    else if (ms == DONE) begin if (!run) ms = LOAD; end
  endtask

  task automatic check();
    bit eb = ms == WAIT || ms == STEP || ms == PAUSED;
    n_cmp++;
    if (int'(state) != ms || load_req != (ms == LOAD) || step_req != (ms == STEP) ||
        busy != eb || sorted != (ms == DONE) || int'(step_count) != msc || (load_req && step_req)) begin
      n_bad++;
      $display("FAIL cycle %0d outputs: state=%0d lr=%0b sr=%0b busy=%0b sorted=%0b sc=%0d, expected state=%0d lr=%0b sr=%0b busy=%0b sorted=%0b sc=%0d",
               cyc_n, state, load_req, step_req, busy, sorted, step_count,
               ms, ms == LOAD, ms == STEP, eb, ms == DONE, msc);
    end
  endtask

  task automatic lit(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check();
    if (step_req && !sr_q) begin rise_gap = cyc_n - last_rise; last_rise = cyc_n; n_rise++; end
    sr_q = step_req;
    cyc_n++;
    step_ack = auto_ack && step_req;
    load_ack = 0;
    step_pulse = 0;
  endtask

  task automatic wait_rise(input int tgt);
    int b = 0;
    while (n_rise < tgt && b < 200) begin cyc(); b++; end
    if (n_rise < tgt) lit("rise_timeout", n_rise, tgt);
  endtask

  task automatic wait_model(input int s, input int c);
    int b = 0;
    while (!(ms == s && mc == c) && b < 200) begin cyc(); b++; end
    if (!(ms == s && mc == c)) lit("model_wait_timeout", ms * 100 + mc, s * 100 + c);
  endtask

  task automatic async_reset();
    #2 reset_n = 0;
    model_reset();
    #1;
    lit("rst_state", int'(state), IDLE);
    lit("rst_reqs", int'({load_req, step_req}), 0);
    lit("rst_flags", int'({busy, sorted}), 0);
    lit("rst_step_count", int'(step_count), 0);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    int hi, n, s0;
    #2 reset_n = 0;
    #1;
    lit("init_state", int'(state), IDLE);
    lit("init_outputs", int'({load_req, step_req, busy, sorted, step_count}), 0);
    repeat (2) cyc();
    @(negedge clk);
    reset_n = 1;
    repeat (3) cyc();
    // load handshake: ack presented on the third cycle of LOAD
    enable = 1;
    hi = 0;
    cyc(); hi += int'(load_req);
    cyc(); hi += int'(load_req);
    cyc(); hi += int'(load_req);
    load_ack = 1;
    cyc();
    lit("load_req_cycles", hi, 3);
    lit("ready_state", int'(state), READY);
    lit("load_req_dropped", int'(load_req), 0);
    lit("sc_after_load", int'(step_count), 0);
    // slow stepping with immediate acks
    auto_ack = 1; run = 1; fast = 0;
    wait_rise(n_rise + 1);
    wait_rise(n_rise + 1);
    lit("slow_gap_1", rise_gap, 9);
    cyc();
    lit("slow_sc_2", int'(step_count), 2);
    wait_rise(n_rise + 1);
    lit("slow_gap_2", rise_gap, 9);
    cyc();
    lit("slow_sc_3", int'(step_count), 3);
    // fast switched mid-WAIT beyond the new limit
    wait_model(WAIT, 5);
    fast = 1;
    cyc();
    lit("fast_switch_step", int'(state), STEP);
    wait_rise(n_rise + 1);
    lit("fast_gap", rise_gap, 3);
    // pause holds the delay count
    fast = 0;
    wait_model(WAIT, 4);
    pause = 1;
    cyc();
    lit("paused_state", int'(state), PAUSED);
    repeat (20) cyc();
    lit("still_paused", int'(state), PAUSED);
    pause = 0;
    cyc();
    lit("resume_wait", int'(state), WAIT);
    n = 0;
    while (!step_req && n < 20) begin cyc(); n++; end
    lit("resume_to_step", n, 4);
`ifdef SORT_STEP_SINGLE_EN
    wait_model(WAIT, 2);
    pause = 1;
    cyc();
    s0 = msc;
    step_pulse = 1;
    cyc();
    lit("single_step", int'(state), STEP);
    cyc();
    lit("single_back_paused", int'(state), PAUSED);
    lit("single_sc", int'(step_count), s0 + 1 > SC_MAX ? SC_MAX : s0 + 1);
    pause = 0;
`else
    wait_model(WAIT, 2);
    pause = 1;
    cyc();
    step_pulse = 1;
    cyc();
    lit("pulse_ignored", int'(state), PAUSED);
    pause = 0;
`endif
    // done after the fifth step of a fresh load
    run = 0;
    repeat (3) cyc();
    enable = 0;
    cyc();
    lit("disable_idle", int'(state), IDLE);
    enable = 1;
    cyc();
    load_ack = 1;
    cyc();
    lit("reload_sc", int'(step_count), 0);
    fast = 1; run = 1;
    wait_rise(n_rise + 5);
    engine_done = 1;
    cyc();
    engine_done = 0;
    lit("done_state", int'(state), DONE);
    lit("done_sorted", int'(sorted), 1);
    lit("done_sc", int'(step_count), 5);
    run = 0;
    cyc();
    lit("done_reload_state", int'(state), LOAD);
    lit("done_reload_req", int'(load_req), 1);
    // enable drop with an outstanding step request
    load_ack = 1;
    cyc();
    auto_ack = 0; run = 1;
    wait_rise(n_rise + 1);
    cyc();
    lit("step_held", int'(step_req), 1);
    enable = 0;
    cyc();
    lit("abort_state", int'(state), IDLE);
    lit("abort_step_req", int'(step_req), 0);
    enable = 1; run = 0;
    cyc();
    load_ack = 1;
    cyc();
    run = 1; auto_ack = 1; fast = 0;
    wait_model(WAIT, 3);
    async_reset();
    auto_ack = 0;
    // randomized traffic
    for (int i = 0; i < 20000; i++) begin
      enable = enable ? ($urandom_range(0, 149) != 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      if ($urandom_range(0, 49) == 0) fast = ~fast;
      step_pulse = $urandom_range(0, 7) == 0;
      step_ack = step_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      load_ack = load_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      engine_done = $urandom_range(0, 24) == 0;
      if ($urandom_range(0, 2999) == 0) async_reset();
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
